fp_round_pack: RTL and testbench
================================

// Module: fp_round_pack
// PURPOSE
//  Final stage of the FP adder, directly downstream of Normalize.
//  - Takes the normalized sign/exponent/fraction plus guard/round/sticky bits.
//  - Applies IEEE-754 round-to-nearest-even and renormalizes on mantissa carry.
//  - Saturates exponent overflow to infinity, then packs a 32-bit single-precision word.
//  - 2-stage valid/ready pipeline, one result per cycle.
// PARAMETERS
//  EXP_W  8   exponent field width
//  MAN_W  23  stored fraction width (hidden bit implied)
// PORTS
//  clk          in   1              clock; all state updates on rising edge
//  rst_n        in   1              reset, asynchronous, active-low
//  in_valid     in   1              upstream operand valid
//  in_ready     out  1              stage can accept this cycle
//  in_sign      in   1              normalized sign
//  in_exp       in   EXP_W          normalized biased exponent
//  in_mant      in   MAN_W          normalized fraction
//  in_grs       in   3              {guard, round, sticky}
//  in_zero      in   1              exact-zero result (cancellation)
//  out_valid    out  1              packed result valid
//  out_ready    in   1              downstream accepts
//  out_result   out  1+EXP_W+MAN_W  {sign, exp, fraction}
//  out_overflow out  1              FP_ROUND_FLAGS_EN only
//  out_inexact  out  1              FP_ROUND_FLAGS_EN only
// BEHAVIOUR
//  - Reset state: s1_valid=0, s2_valid=0, out_valid=0, out_result=0, flags=0. in_ready=1 while rst_n=0.
//  - Reset mid-operation: in-flight entries are discarded; no output follows release.
//  - Advance enables:
//    - s2_en = !s2_valid | out_ready
//    - s1_en = !s1_valid | s2_en
//    - in_ready = s1_en (combinational from out_ready; accepted path)
//  - Accept = in_valid & in_ready.
//  - S1 (register):
//    - latch sign, exp, mant, zero
//    - rnd_up = G & (R | S | mant[0])
//    - inexact = |grs & !zero
//  - S2 (register), computed from S1:
//    - sum = {1'b0,mant} + rnd_up (MAN_W+1 bits)
//    - sum[MAN_W]=1: fraction=0, exp=exp+1
//    - exp result == all-ones (from rounding carry): fraction=0, overflow=1 (+/-inf)
//    - in_exp == all-ones on input: passes unchanged, no rounding (inf/NaN)
//    - zero=1: result = {sign, 0...0}, grs ignored, flags 0
//  - Latency 2 cycles accept->out_valid with out_ready=1; throughput 1/cycle.
//  - Stall: out_valid & !out_ready holds out_result and flags stable. S1 fills, then in_ready=0.
//  - Simultaneous output pop and input accept when full: allowed, no bubble.
//  - out_valid never drops without out_ready handshake (except reset).
//  - Ordering strictly FIFO.
// CONFIGURATION
//  FP_ROUND_FLAGS_EN defined:
//    - out_overflow / out_inexact ports exist
//    - registered alongside out_result; same stall rules
//  FP_ROUND_FLAGS_EN undefined:
//    - ports and flag registers absent
//    - result datapath identical
// STRUCTURE
//  fp_pkg:
//    - EXP_W, MAN_W, EXP_MAX = '1
//    - typedef struct packed {sign, exp, frac} fp32_t
//    - typedef struct packed {g, r, s} grs_t
//  Sub-module fp_rne_incr (combinational): mant, grs -> rnd_up, inexact.
//  Top holds the two pipeline registers and handshake.
// TESTING
//  1. exp=7F mant=400000 grs=000 -> 3FC00000 two cycles later; inexact=0.
//  2. Tie: mant=000001 grs=100 exp=7F -> 3F800002.
//     mant=000000 grs=100 -> 3F800000; inexact=1 both.
//  3. Carry: exp=7F mant=7FFFFF grs=110 -> 40000000.
//  4. Overflow: exp=FE mant=7FFFFF grs=100 sign=1 -> FF800000, overflow=1.
//  5. Backpressure: stream 4 ops, out_ready low 3 cycles after first out_valid:
//     - out_result stable while stalled
//     - in_ready=0 once both stages full
//     - all 4 delivered in order, none duplicated
//  6. Reset mid-flight: rst_n low with 2 entries held:
//     - out_valid=0 asynchronously
//     - nothing emitted after release
//     - first new op appears 2 cycles after accept

Source files
------------

// File: rtl/fp_pkg.sv
// Shared widths and packed types for the single-precision round/pack stage.
package fp_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam logic [EXP_W-1:0] EXP_MAX = '1;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] frac;
   } fp32_t;

   typedef struct packed {
      logic g;
      logic r;
      logic s;
   } grs_t;

endpackage

// File: rtl/fp_rne_incr.sv
// Round-to-nearest-even decision from the fraction LSB and guard/round/sticky.
// The inexact output exists only when FP_ROUND_FLAGS_EN is defined.
module fp_rne_incr
   import fp_pkg::*;
(
   input  logic mant_lsb,
   input  grs_t grs,
   output logic rnd_up
`ifdef FP_ROUND_FLAGS_EN
   ,
   output logic inexact
`endif
);

   // Exact ties (G=1, R=S=0) round up only when that makes the fraction even.
   assign rnd_up = grs.g & (grs.r | grs.s | mant_lsb);

`ifdef FP_ROUND_FLAGS_EN
   assign inexact = |grs;
`endif

endmodule

// File: rtl/fp_round_pack.sv
// Rounding, overflow saturation and packing stage of the FP adder, 2-stage valid/ready.
// Optional out_overflow/out_inexact flags are built when FP_ROUND_FLAGS_EN is defined.
module fp_round_pack
   import fp_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_sign,
   input  logic [EXP_W-1:0]         in_exp,
   input  logic [MAN_W-1:0]         in_mant,
   input  logic [2:0]               in_grs,
   input  logic                     in_zero,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [1+EXP_W+MAN_W-1:0] out_result
`ifdef FP_ROUND_FLAGS_EN
   ,
   output logic                     out_overflow,
   output logic                     out_inexact
`endif
);

   logic             s1_en, s2_en, accept;
   logic             s1_valid, s2_valid;
   logic             s1_sign, s1_zero, s1_rnd_up;
   logic [EXP_W-1:0] s1_exp;
   logic [MAN_W-1:0] s1_mant;
   logic             rne_rnd_up;
   grs_t             grs;
   fp32_t            s2_data, s2_next;
   logic [MAN_W:0]   sum;
   logic [EXP_W-1:0] exp_n;
`ifdef FP_ROUND_FLAGS_EN
   logic             s1_inexact, rne_inexact, s2_ovf_next;
`endif

   assign s2_en    = !s2_valid | out_ready;
   assign s1_en    = !s1_valid | s2_en;
   assign in_ready = s1_en;
   assign accept   = in_valid & in_ready;
   assign grs      = grs_t'(in_grs);

   fp_rne_incr u_rne (
      .mant_lsb (in_mant[0]),
      .grs      (grs),
      .rnd_up   (rne_rnd_up)
`ifdef FP_ROUND_FLAGS_EN
      ,
      .inexact  (rne_inexact)
`endif
   );

   // NOTE: every signal gets a default before the branches, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      sum     = {1'b0, s1_mant} + {{MAN_W{1'b0}}, s1_rnd_up};
      exp_n   = s1_exp + {{(EXP_W-1){1'b0}}, sum[MAN_W]};
      s2_next = '{sign: s1_sign, exp: s1_exp, frac: s1_mant};
`ifdef FP_ROUND_FLAGS_EN
      s2_ovf_next = 1'b0;
`endif
      if (s1_zero) begin
         s2_next = '{sign: s1_sign, exp: '0, frac: '0};
      end else if (s1_exp != EXP_MAX) begin
         // A carry out of the fraction leaves sum's low bits zero, so frac is already 0.
         s2_next.exp  = exp_n;
         s2_next.frac = sum[MAN_W-1:0];
         if (exp_n == EXP_MAX) begin
            s2_next.frac = '0;
`ifdef FP_ROUND_FLAGS_EN
            s2_ovf_next  = 1'b1;
`endif
         end
      end
   end

   // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
   // NOTE: datapath registers are reset too, so out_result reads as zero straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_sign   <= 1'b0;
         s1_exp    <= '0;
         s1_mant   <= '0;
         s1_zero   <= 1'b0;
         s1_rnd_up <= 1'b0;
`ifdef FP_ROUND_FLAGS_EN
         s1_inexact <= 1'b0;
`endif
      end else begin
         if (s1_en) s1_valid <= in_valid;
         if (accept) begin
            s1_sign   <= in_sign;
            s1_exp    <= in_exp;
            s1_mant   <= in_mant;
            s1_zero   <= in_zero;
            s1_rnd_up <= rne_rnd_up;
`ifdef FP_ROUND_FLAGS_EN
            s1_inexact <= rne_inexact & !in_zero;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_data  <= '0;
`ifdef FP_ROUND_FLAGS_EN
         out_overflow <= 1'b0;
         out_inexact  <= 1'b0;
`endif
      end else if (s2_en) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_data <= s2_next;
`ifdef FP_ROUND_FLAGS_EN
            out_overflow <= s2_ovf_next;
            out_inexact  <= s1_inexact;
`endif
         end
      end
   end

   assign out_valid  = s2_valid;
   assign out_result = s2_data;

endmodule

// File: tb/tb_fp_round_pack.sv
// Randomized and directed bench for fp_round_pack against an arithmetic rounding model.
// Flag comparisons are compiled in when FP_ROUND_FLAGS_EN is defined.
module tb_fp_round_pack;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] mant;
      logic [2:0]  grs;
      logic        zero;
   } op_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_sign = 1'b0;
   logic [7:0]  in_exp = '0;
   logic [22:0] in_mant = '0;
   logic [2:0]  in_grs = '0;
   logic        in_zero = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_result;
`ifdef FP_ROUND_FLAGS_EN
   logic        out_overflow, out_inexact;
`endif

   int total = 0;
   int bad   = 0;

   fp_round_pack dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sign    (in_sign),
      .in_exp     (in_exp),
      .in_mant    (in_mant),
      .in_grs     (in_grs),
      .in_zero    (in_zero),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result)
`ifdef FP_ROUND_FLAGS_EN
      ,
      .out_overflow (out_overflow),
      .out_inexact  (out_inexact)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // Reference: {overflow, inexact, result}, built from the 24-bit significand value.
   function automatic logic [33:0] model(op_t o);
      int unsigned sig, e;
      logic ovf, inx;
      ovf = 1'b0;
      inx = (o.grs != 3'b000);
      if (o.zero) return {2'b00, o.sign, 31'd0};
      if (o.exp == 8'hFF) return {1'b0, inx, o.sign, o.exp, o.mant};
      sig = 32'h0080_0000 + 32'(o.mant);
      if (o.grs[2] && (o.grs[1] || o.grs[0] || (sig % 2 == 1))) sig = sig + 1;
      e = 32'(o.exp);
      if (sig == 32'h0100_0000) begin
         sig = sig / 2;
         e = e + 1;
      end
      if (e == 255) begin
         ovf = 1'b1;
         sig = 32'h0080_0000;
      end
      return {ovf, inx, o.sign, 8'(e), 23'(sig)};
   endfunction

   function automatic op_t rand_op();
      op_t o;
      int unsigned pick;
      pick   = $urandom_range(0, 9);
      o.sign = 1'($urandom);
      o.exp  = (pick == 0) ? 8'hFE : (pick == 1) ? 8'hFF : 8'($urandom_range(1, 254));
      o.mant = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF : 23'($urandom);
      o.grs  = 3'($urandom);
      o.zero = ($urandom_range(0, 9) == 0);
      return o;
   endfunction

   task automatic drive_op(op_t o);
      in_sign = o.sign;
      in_exp  = o.exp;
      in_mant = o.mant;
      in_grs  = o.grs;
      in_zero = o.zero;
   endtask

   task automatic test_reset();
      in_valid = 1'b1;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++;
      if (out_result !== 32'h0) begin bad++; $display("FAIL reset_out_result got=%h want=00000000", out_result); end
`ifdef FP_ROUND_FLAGS_EN
      total++;
      if ({out_overflow, out_inexact} !== 2'b00) begin
         bad++; $display("FAIL reset_flags got=%b%b want=00", out_overflow, out_inexact);
      end
`endif
      in_valid = 1'b0;
      out_ready = 1'b1;
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      op_t         ops [8];
      logic [31:0] want [8];
      logic [1:0]  wflg [8];
      ops[0] = '{1'b0, 8'h7F, 23'h400000, 3'b000, 1'b0}; want[0] = 32'h3FC00000; wflg[0] = 2'b00;
      ops[1] = '{1'b0, 8'h7F, 23'h000001, 3'b100, 1'b0}; want[1] = 32'h3F800002; wflg[1] = 2'b01;
      ops[2] = '{1'b0, 8'h7F, 23'h000000, 3'b100, 1'b0}; want[2] = 32'h3F800000; wflg[2] = 2'b01;
      ops[3] = '{1'b0, 8'h7F, 23'h7FFFFF, 3'b110, 1'b0}; want[3] = 32'h40000000; wflg[3] = 2'b01;
      ops[4] = '{1'b1, 8'hFE, 23'h7FFFFF, 3'b100, 1'b0}; want[4] = 32'hFF800000; wflg[4] = 2'b11;
      ops[5] = '{1'b1, 8'h42, 23'h1ABCDE, 3'b111, 1'b1}; want[5] = 32'h80000000; wflg[5] = 2'b00;
      ops[6] = '{1'b0, 8'hFF, 23'h000000, 3'b000, 1'b0}; want[6] = 32'h7F800000; wflg[6] = 2'b00;
      ops[7] = '{1'b0, 8'h7F, 23'h123456, 3'b011, 1'b0}; want[7] = 32'h3F923456; wflg[7] = 2'b01;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         drive_op(ops[i]);
         in_valid = 1'b1;
         out_ready = 1'b1;
         @(negedge clk);
         total++;
         if (in_ready !== 1'b1) begin bad++; $display("FAIL dir%0d_in_ready got=%b want=1", i, in_ready); end
         @(posedge clk); #1;
         in_valid = 1'b0;
         @(negedge clk);
         total++;
         if (out_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_early_valid got=%b want=0", i, out_valid); end
         @(posedge clk); #1;
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || out_result !== want[i]) begin
            bad++; $display("FAIL dir%0d_result valid=%b got=%h want=%h", i, out_valid, out_result, want[i]);
         end
`ifdef FP_ROUND_FLAGS_EN
         total++;
         if ({out_overflow, out_inexact} !== wflg[i]) begin
            bad++; $display("FAIL dir%0d_flags got=%b%b want=%b", i, out_overflow, out_inexact, wflg[i]);
         end
`endif
      end
   endtask

   task automatic test_backpressure();
      op_t         ops [4];
      logic [33:0] exp_q [4];
      logic [31:0] held;
      int sent = 0, got = 0, stall_left = 0;
      bit stalled_once = 0;
      for (int i = 0; i < 4; i++) begin
         ops[i]   = rand_op();
         exp_q[i] = model(ops[i]);
      end
      held = '0;
      for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
         @(posedge clk); #1;
         in_valid = (sent < 4);
         if (sent < 4) drive_op(ops[sent]);
         if (!stalled_once && out_valid) begin
            stalled_once = 1;
            stall_left = 3;
            held = out_result;
         end
         out_ready = (stall_left == 0);
         @(negedge clk);
         if (stall_left > 0) begin
            total++;
            if (out_valid !== 1'b1 || out_result !== held) begin
               bad++; $display("FAIL bp_stall_hold valid=%b got=%h want=%h", out_valid, out_result, held);
            end
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_full got=%b want=0", in_ready); end
            stall_left--;
         end
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) begin
            total++;
            if (out_result !== exp_q[got][31:0]) begin
               bad++; $display("FAIL bp_order idx=%0d got=%h want=%h", got, out_result, exp_q[got][31:0]);
            end
            got++;
         end
      end
      total++;
      if (got != 4 || !stalled_once) begin
         bad++; $display("FAIL bp_delivered got=%0d want=4 stalled=%0d", got, stalled_once);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_duplicate got=%b want=0", out_valid); end
   endtask

   task automatic test_random();
      logic [33:0] sb [$];
      logic [31:0] prev_res;
      logic [33:0] e;
      op_t cur;
      bit prev_stall = 0;
      cur = rand_op();
      prev_res = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(posedge clk); #1;
         in_valid = (cyc < 380) && ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6) || (cyc >= 380);
         drive_op(cur);
         @(negedge clk);
         if (prev_stall) begin
            total++;
            if (out_valid !== 1'b1 || out_result !== prev_res) begin
               bad++; $display("FAIL rnd_stall_hold valid=%b got=%h want=%h", out_valid, out_result, prev_res);
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back(model(cur));
            cur = rand_op();
         end
         if (out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
               bad++; $display("FAIL rnd_spurious got=%h want=none", out_result);
            end else begin
               e = sb.pop_front();
               if (out_result !== e[31:0]) begin
                  bad++; $display("FAIL rnd_result got=%h want=%h", out_result, e[31:0]);
               end
`ifdef FP_ROUND_FLAGS_EN
               total++;
               if ({out_overflow, out_inexact} !== e[33:32]) begin
                  bad++; $display("FAIL rnd_flags got=%b%b want=%b", out_overflow, out_inexact, e[33:32]);
               end
`endif
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_res = out_result;
      end
      total++;
      if (sb.size() != 0) begin bad++; $display("FAIL rnd_drain left=%0d want=0", sb.size()); end
   endtask

   task automatic test_reset_midflight();
      op_t a, b, c;
      logic [33:0] e;
      a = rand_op(); b = rand_op(); c = rand_op();
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = 1'b1;
      drive_op(a);
      @(posedge clk); #1;
      drive_op(b);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_held_valid got=%b want=1", out_valid); end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid got=%b want=0", out_valid); end
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_async_in_ready got=%b want=1", in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_ghost cyc=%0d got=%b want=0", i, out_valid); end
      end
      @(posedge clk); #1;
      in_valid = 1'b1;
      drive_op(c);
      e = model(c);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_new_early got=%b want=0", out_valid); end
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_result !== e[31:0]) begin
         bad++; $display("FAIL rst_new_result valid=%b got=%h want=%h", out_valid, out_result, e[31:0]);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_random();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
